fxp_to_fp_pipe: RTL and testbench
=================================

FXP_TO_FP_PIPE -- requirements
Module: fxp_to_fp_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning fixed-point input width; legal range 8..64.
REQ-002 SHALL have parameter FRAC_W, default 16, meaning fraction bits of input; legal range 0..IN_W-1.
REQ-003 SHALL have parameter SIGNED_IN, default 1, meaning 1 = two's-complement input, 0 = unsigned input.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port in_data  input  IN_W  fixed-point value.
REQ-009 SHALL have port in_rmode  input  1  per-beat rounding: 0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ).
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_fp  output  32  IEEE-754 single {sign, exp[7:0], man[22:0]}.
REQ-013 SHALL have port out_inexact  output  1  result differs from exact input value.

Function
REQ-014 SHALL transfer a beat when valid and ready are both high on a rising clk edge, on either side.
REQ-015 SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 leading-one detect + normalise, S3 round + pack; latency 3 cycles with out_ready held high.
REQ-016 SHALL sustain one beat per cycle when out_ready is high.
REQ-017 SHALL advance each stage when its successor is empty or advancing; bubbles collapse; in_ready = S1 empty or S1 advancing.
REQ-018 SHALL hold out_fp, out_inexact stable while out_valid=1 and out_ready=0.
REQ-019 SHALL compute magnitude as IN_W+1-bit two's-complement negation when SIGNED_IN=1 and MSB=1, so the most negative input converts exactly; sign=0 when SIGNED_IN=0.
REQ-020 SHALL set exponent = 127 + p - FRAC_W, where p = index of leading one in magnitude.
REQ-021 SHALL keep 24 significant bits (hidden one + 23); when p <= 23 shift left, exact, inexact=0.
REQ-022 SHALL, when p > 23, form guard bit and sticky (OR of lower dropped bits) and round per in_rmode of that beat.
REQ-023 SHALL, on RNE, increment when guard=1 and (sticky=1 or kept LSB=1); on RTZ, truncate.
REQ-024 SHALL, on rounding carry out of 24 bits, set mantissa to 0 and increment exponent.
REQ-025 SHALL set out_inexact = guard OR sticky.
REQ-026 SHALL output 0x00000000 with inexact=0 for zero input (never -0).
REQ-027 SHALL never produce denormal, infinity or NaN; the parameter ranges guarantee a normal exponent.
REQ-028 SHALL carry in_rmode down the pipeline with its beat.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear all stage valid bits; out_valid=0, out_fp=0, out_inexact=0.
REQ-030 SHALL drop beats in flight at mid-operation reset with no partial output; in_ready=1 from first edge after release.
REQ-031 SHALL leave datapath registers other than outputs unreset.

Structure
REQ-032 SHALL take FP32_EXP_W=8, FP32_MAN_W=23, FP32_BIAS=127 and rounding-mode enum (RM_RNE, RM_RTZ) from shared package fpu_pkg.
REQ-033 SHALL instantiate one sub-module lead_one_det (parametrised width, returns index and found flag), reused by later FPU blocks.
REQ-034 SHALL check parameter legality at elaboration and fail on illegal values.

Verification (IN_W=32, FRAC_W=16, SIGNED_IN=1)
REQ-035 SHALL cover: in_data 0x00010000 RNE -> out_fp 0x3F800000, inexact 0, out_valid 3 cycles after accept.
REQ-036 SHALL cover: 0xFFFF0000 -> 0xBF800000; 0x80000000 -> 0xC7000000; 0x00000000 -> 0x00000000; all inexact 0.
REQ-037 SHALL cover: 0x7FFFFFFF RNE -> 0x47000000 inexact 1 (carry into exponent); RTZ -> 0x46FFFFFF inexact 1.
REQ-038 SHALL cover: 0x01000001 RNE -> 0x43800000 inexact 1 (tie to even).
REQ-039 SHALL cover: 8-beat back-to-back stream with out_ready toggled pseudo-randomly -> results in order, none lost or duplicated, outputs stable while stalled.
REQ-040 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid 0 immediately, no stale result after release.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_pkg
// Brief  : Shared FP32 field widths, bias, rounding-mode encoding and a
//          field-packing helper used across the FPU blocks.
// Rev    : 1.0  initial release
// ============================================================================
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  // Rounding mode encoding matches the per-beat in_rmode pin
  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rmode_e;

  // Assemble an IEEE-754 single from its fields
  function automatic logic [31:0] fp32_pack(
    input logic                  sign,
    input logic [FP32_EXP_W-1:0] exp,
    input logic [FP32_MAN_W-1:0] man
  );
    return {sign, exp, man};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lead_one_det.sv
`default_nettype none
// ============================================================================
// Module : lead_one_det
// Brief  : Combinational leading-one detector. Returns the bit index of the
//          most significant set bit and a found flag (0 when vec is zero).
// Rev    : 1.0  initial release
// ============================================================================
module lead_one_det #(
  parameter int W     = 32,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan upward; the last set bit seen is the most significant one
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fxp_to_fp_pipe.sv
`default_nettype none
// ============================================================================
// Module : fxp_to_fp_pipe
// Brief  : Three-stage valid/ready pipeline converting a fixed-point value
//          (IN_W bits, FRAC_W fraction bits, signed or unsigned) to IEEE-754
//          single precision with per-beat RNE/RTZ rounding and inexact flag.
//          S1 sign/magnitude, S2 leading-one detect + normalise,
//          S3 round + pack (the output register).
// Rev    : 1.0  initial release
// ============================================================================
module fxp_to_fp_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int FRAC_W    = 16,
  parameter int SIGNED_IN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_rmode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_fp,
  output logic            out_inexact
);

  localparam int c_idx_w = $clog2(IN_W);
  localparam int c_ext_w = IN_W + 24;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // --------------------------------------------------------------------------
  generate
    if (IN_W < 8 || IN_W > 64) begin : g_bad_in_w
      $error("fxp_to_fp_pipe: IN_W=%0d outside 8..64", IN_W);
    end
    if (FRAC_W < 0 || FRAC_W > IN_W - 1) begin : g_bad_frac_w
      $error("fxp_to_fp_pipe: FRAC_W=%0d outside 0..IN_W-1", FRAC_W);
    end
    if (SIGNED_IN != 0 && SIGNED_IN != 1) begin : g_bad_signed_in
      $error("fxp_to_fp_pipe: SIGNED_IN=%0d must be 0 or 1", SIGNED_IN);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or its content is leaving
  // --------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s3_open;
  logic w_s2_open;
  logic w_s1_open;
  logic w_in_fire;

  assign w_s3_open = !out_valid || out_ready;
  assign w_s2_open = !r_s2_valid || w_s3_open;
  assign w_s1_open = !r_s1_valid || w_s2_open;
  assign in_ready  = w_s1_open;
  assign w_in_fire = in_valid && w_s1_open;

  // --------------------------------------------------------------------------
  // S1 combinational: sign and magnitude.
  // The negation is the low IN_W bits of the IN_W+1-bit two's complement
  // negate; read as unsigned it is exact even for the most negative input
  // (2^(IN_W-1) fits in IN_W unsigned bits), so the extra top bit is dropped.
  // --------------------------------------------------------------------------
  localparam logic [IN_W-1:0] c_one = {{(IN_W-1){1'b0}}, 1'b1};

  logic            w_in_neg;
  logic [IN_W-1:0] w_in_mag;

  assign w_in_neg = (SIGNED_IN != 0) && in_data[IN_W-1];
  assign w_in_mag = w_in_neg ? (~in_data + c_one) : in_data;

  logic            r_s1_sign;
  logic [IN_W-1:0] r_s1_mag;
  rmode_e          r_s1_rm;

  // --------------------------------------------------------------------------
  // S2 combinational: leading-one detect and normalise. The leading one is
  // shifted out so the fraction bits sit left-aligned in w_frac.
  // --------------------------------------------------------------------------
  logic [c_idx_w-1:0] w_lod_idx;
  logic               w_lod_found;
  logic [c_idx_w-1:0] w_shamt;
  logic [c_idx_w:0]   w_fshamt;
  logic [IN_W-1:0]    w_frac;

  lead_one_det #(
    .W     (IN_W),
    .IDX_W (c_idx_w)
  ) u_lod (
    .vec   (r_s1_mag),
    .idx   (w_lod_idx),
    .found (w_lod_found)
  );

  assign w_shamt  = c_idx_w'(IN_W - 1) - w_lod_idx;
  assign w_fshamt = {1'b0, w_shamt} + {{c_idx_w{1'b0}}, 1'b1};
  assign w_frac   = r_s1_mag << w_fshamt;

  logic               r_s2_sign;
  logic               r_s2_zero;
  logic [c_idx_w-1:0] r_s2_p;
  logic [IN_W-1:0]    r_s2_frac;
  rmode_e             r_s2_rm;

  // --------------------------------------------------------------------------
  // S3 combinational: round to 23 stored fraction bits and pack.
  // Appending 24 zeros guarantees guard/sticky positions exist for any IN_W;
  // when p <= 23 every dropped bit is zero, so the result is exact.
  // --------------------------------------------------------------------------
  logic [c_ext_w-1:0]    w_ext;
  logic [FP32_MAN_W-1:0] w_man_trunc;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic                  w_carry;
  logic [FP32_MAN_W-1:0] w_man_rnd;
  logic [FP32_MAN_W-1:0] w_man;
  logic [FP32_EXP_W-1:0] w_exp;
  logic [31:0]           w_fp;
  logic                  w_inexact;

  assign w_ext       = {r_s2_frac, 24'd0};
  assign w_man_trunc = w_ext[c_ext_w-1 -: FP32_MAN_W];
  assign w_guard     = w_ext[IN_W];
  assign w_sticky    = |w_ext[IN_W-1:0];
  assign w_round_up  = (r_s2_rm == RM_RNE) && w_guard && (w_sticky || w_man_trunc[0]);

  // Carry out of the stored fraction means the 24-bit significand overflowed
  assign {w_carry, w_man_rnd} = {1'b0, w_man_trunc} + {{FP32_MAN_W{1'b0}}, w_round_up};
  assign w_man = w_carry ? '0 : w_man_rnd;

  // True exponent lies well inside 1..254 for legal parameters, so 8-bit
  // modular arithmetic yields the exact biased value
  assign w_exp = FP32_EXP_W'(FP32_BIAS) + FP32_EXP_W'(r_s2_p)
               - FP32_EXP_W'(FRAC_W) + FP32_EXP_W'(w_carry);

  assign w_fp      = r_s2_zero ? 32'd0 : fp32_pack(r_s2_sign, w_exp, w_man);
  assign w_inexact = !r_s2_zero && (w_guard || w_sticky);

  // --------------------------------------------------------------------------
  // Stage valid bits: cleared asynchronously, bubbles collapse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_open) r_s1_valid <= in_valid;
      if (w_s2_open) r_s2_valid <= r_s1_valid;
    end
  end

  // Output register: updates only when empty or being consumed, holds on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_fp      <= 32'd0;
      out_inexact <= 1'b0;
    end else if (w_s3_open) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_fp      <= w_fp;
        out_inexact <= w_inexact;
      end
    end
  end

  // Internal datapath registers carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_sign <= w_in_neg;
      r_s1_mag  <= w_in_mag;
      r_s1_rm   <= rmode_e'(in_rmode);
    end
    if (w_s2_open && r_s1_valid) begin
      r_s2_sign <= r_s1_sign && w_lod_found;
      r_s2_zero <= !w_lod_found;
      r_s2_p    <= w_lod_idx;
      r_s2_frac <= w_frac;
      r_s2_rm   <= r_s1_rm;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fxp_to_fp_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_fxp_to_fp_pipe
// Brief  : Directed self-checking bench for fxp_to_fp_pipe
//          (IN_W=32, FRAC_W=16, SIGNED_IN=1).
// Rev    : 1.0  initial release
// ============================================================================
module tb_fxp_to_fp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_rmode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_fp;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  // Directed vectors with hand-computed results (rm: 0 = RNE, 1 = RTZ)
  logic [31:0] v_data [12];
  logic        v_rm   [12];
  logic [31:0] v_fp   [12];
  logic        v_inx  [12];
  int          seq    [8];

  always #5 clk = ~clk;

  fxp_to_fp_pipe #(
    .IN_W      (32),
    .FRAC_W    (16),
    .SIGNED_IN (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_rmode    (in_rmode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_fp      (out_fp),
    .out_inexact (out_inexact)
  );

  task automatic load_tables();
    v_data[0]  = 32'h0001_0000; v_rm[0]  = 1'b0; v_fp[0]  = 32'h3F80_0000; v_inx[0]  = 1'b0; //  1.0
    v_data[1]  = 32'hFFFF_0000; v_rm[1]  = 1'b0; v_fp[1]  = 32'hBF80_0000; v_inx[1]  = 1'b0; // -1.0
    v_data[2]  = 32'h8000_0000; v_rm[2]  = 1'b0; v_fp[2]  = 32'hC700_0000; v_inx[2]  = 1'b0; // -32768
    v_data[3]  = 32'h0000_0000; v_rm[3]  = 1'b0; v_fp[3]  = 32'h0000_0000; v_inx[3]  = 1'b0; // zero
    v_data[4]  = 32'h7FFF_FFFF; v_rm[4]  = 1'b0; v_fp[4]  = 32'h4700_0000; v_inx[4]  = 1'b1; // carry
    v_data[5]  = 32'h7FFF_FFFF; v_rm[5]  = 1'b1; v_fp[5]  = 32'h46FF_FFFF; v_inx[5]  = 1'b1; // truncate
    v_data[6]  = 32'h0100_0001; v_rm[6]  = 1'b0; v_fp[6]  = 32'h4380_0000; v_inx[6]  = 1'b1; // tie, even
    v_data[7]  = 32'h0100_0003; v_rm[7]  = 1'b0; v_fp[7]  = 32'h4380_0002; v_inx[7]  = 1'b1; // tie, odd
    v_data[8]  = 32'h0100_0003; v_rm[8]  = 1'b1; v_fp[8]  = 32'h4380_0001; v_inx[8]  = 1'b1;
    v_data[9]  = 32'h0000_0001; v_rm[9]  = 1'b0; v_fp[9]  = 32'h3780_0000; v_inx[9]  = 1'b0; // 2^-16
    v_data[10] = 32'h0001_8000; v_rm[10] = 1'b0; v_fp[10] = 32'h3FC0_0000; v_inx[10] = 1'b0; //  1.5
    v_data[11] = 32'hFFFF_FFFF; v_rm[11] = 1'b0; v_fp[11] = 32'hB780_0000; v_inx[11] = 1'b0; // -2^-16
    seq[0] = 0; seq[1] = 4; seq[2] = 5; seq[3] = 2;
    seq[4] = 6; seq[5] = 8; seq[6] = 3; seq[7] = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_fp !== 32'd0) begin
      errors++; $display("FAIL reset_out_fp: got %h expected 00000000", out_fp);
    end
    checks++;
    if (out_inexact !== 1'b0) begin
      errors++; $display("FAIL reset_out_inexact: got %b expected 0", out_inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    int n;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = v_data[i];
      in_rmode  = v_rm[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (n < 10) begin
        @(negedge clk);
        n++;
        if (out_valid === 1'b1) break;
      end
      checks++;
      if (n != 3) begin
        errors++; $display("FAIL vec%0d_latency: got %0d cycles expected 3", i, n);
      end
      checks++;
      if (out_fp !== v_fp[i]) begin
        errors++; $display("FAIL vec%0d_fp in=%h rm=%b: got %h expected %h",
                           i, v_data[i], v_rm[i], out_fp, v_fp[i]);
      end
      checks++;
      if (out_inexact !== v_inx[i]) begin
        errors++; $display("FAIL vec%0d_inexact: got %b expected %b", i, out_inexact, v_inx[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          extra = 0;
    logic        acc;
    logic        deq;
    logic        stall_prev = 1'b0;
    logic [31:0] fp_prev = 32'd0;
    logic        inx_prev = 1'b0;
    while (got < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data  = v_data[seq[sent]];
        in_rmode = v_rm[seq[sent]];
      end
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_fp !== fp_prev || out_inexact !== inx_prev) begin
          errors++; $display("FAIL b2b_stall_hold: got v=%b fp=%h x=%b expected v=1 fp=%h x=%b",
                             out_valid, out_fp, out_inexact, fp_prev, inx_prev);
        end
      end
      acc        = in_valid && in_ready;
      deq        = out_valid && out_ready;
      stall_prev = out_valid && !out_ready;
      fp_prev    = out_fp;
      inx_prev   = out_inexact;
      if (deq) begin
        checks++;
        if (out_fp !== v_fp[seq[got]] || out_inexact !== v_inx[seq[got]]) begin
          errors++; $display("FAIL b2b_result%0d: got %h/%b expected %h/%b",
                             got, out_fp, out_inexact, v_fp[seq[got]], v_inx[seq[got]]);
        end
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    checks++;
    if (got != 8 || sent != 8) begin
      errors++; $display("FAIL b2b_count: got %0d out / %0d in expected 8 / 8", got, sent);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL b2b_duplicate: got %0d extra results expected 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    int n;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data  = v_data[k];
      in_rmode = v_rm[k];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_prefill: got out_valid %b expected 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_fp !== 32'd0 || out_inexact !== 1'b0) begin
      errors++; $display("FAIL midrst_async_clear: got v=%b fp=%h x=%b expected 0/00000000/0",
                         out_valid, out_fp, out_inexact);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_stale: got %0d stale results expected 0", seen);
    end
    // A fresh beat after reset converts normally
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v_data[10];
    in_rmode = v_rm[10];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (n != 3 || out_fp !== v_fp[10]) begin
      errors++; $display("FAIL midrst_fresh: got %h after %0d cycles expected %h after 3",
                         out_fp, n, v_fp[10]);
    end
  endtask

  initial begin
    load_tables();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
